// File: rtl/spi_pkg.sv
// Shared SPI definitions used by both the SPI master and the SPI slave.
// Holds the frame state encodings and the command-bit values.
package spi_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        HOLD  = 2'd2,
        GAP   = 2'd3
    } spi_state_t;

    localparam logic CMD_READ  = 1'b0;
    localparam logic CMD_WRITE = 1'b1;

endpackage

// File: rtl/spi_clk_div.sv
// Half-period tick generator for the SPI clock.
// half_tick pulses on every CLK_DIV-th enabled cycle; the counter holds at zero while disabled.
module spi_clk_div #(
    parameter int CLK_DIV = 4
) (
    input  logic sclk,
    input  logic rst,
    input  logic en,
    output logic half_tick
);

    localparam int CNT_W = (CLK_DIV < 2) ? 1 : $clog2(CLK_DIV + 1);

    logic [CNT_W-1:0] cnt;

    assign half_tick = en && (cnt == CNT_W'(CLK_DIV - 1));

    always_ff @(posedge sclk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (!en || half_tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/spi_master_ctrl.sv
// SPI initiator for the 1-command-bit + DATA_WIDTH-data-bit frame, SPI mode 0.
// Every pin and status output is a register; the comb block computes next values.
module spi_master_ctrl
    import spi_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int CLK_DIV    = 4
) (
    input  logic                  sclk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  rw,
    input  logic [DATA_WIDTH-1:0] tx_data,
    output logic                  busy,
    output logic                  done,
    output logic [DATA_WIDTH-1:0] rx_data,
    output logic                  cs_n,
    output logic                  spi_clk,
    output logic                  mosi,
    input  logic                  miso
);

    localparam int BIT_W = $clog2(DATA_WIDTH + 2);

    spi_state_t            state, state_next;
    logic [BIT_W-1:0]      bit_cnt, bit_cnt_next;
    logic [DATA_WIDTH-1:0] tx_shift, tx_shift_next;
    logic [DATA_WIDTH-1:0] rx_shift, rx_shift_next;
    logic [DATA_WIDTH-1:0] rx_data_next;
    logic                  rw_lat, rw_lat_next;
    logic                  cs_n_next, spi_clk_next, mosi_next, busy_next, done_next;
    logic                  half_tick;

    spi_clk_div #(.CLK_DIV(CLK_DIV)) u_clk_div (
        .sclk      (sclk),
        .rst       (rst),
        .en        (state != IDLE),
        .half_tick (half_tick)
    );

    always_ff @(posedge sclk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            bit_cnt  <= '0;
            tx_shift <= '0;
            rx_shift <= '0;
            rx_data  <= '0;
            rw_lat   <= CMD_READ;
            cs_n     <= 1'b1;
            spi_clk  <= 1'b0;
            mosi     <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            state    <= state_next;
            bit_cnt  <= bit_cnt_next;
            tx_shift <= tx_shift_next;
            rx_shift <= rx_shift_next;
            rx_data  <= rx_data_next;
            rw_lat   <= rw_lat_next;
            cs_n     <= cs_n_next;
            spi_clk  <= spi_clk_next;
            mosi     <= mosi_next;
            busy     <= busy_next;
            done     <= done_next;
        end
    end

    always_comb begin
        state_next    = state;
        bit_cnt_next  = bit_cnt;
        tx_shift_next = tx_shift;
        rx_shift_next = rx_shift;
        rx_data_next  = rx_data;
        rw_lat_next   = rw_lat;
        cs_n_next     = cs_n;
        spi_clk_next  = spi_clk;
        mosi_next     = mosi;
        busy_next     = busy;
        done_next     = 1'b0;

        unique case (state)
            IDLE: begin
                if (start) begin
                    state_next    = SHIFT;
                    rw_lat_next   = rw;
                    tx_shift_next = tx_data;
                    bit_cnt_next  = '0;
                    cs_n_next     = 1'b0;
                    spi_clk_next  = 1'b0;
                    mosi_next     = rw;
                    busy_next     = 1'b1;
                end
            end
            SHIFT: begin
                if (half_tick && !spi_clk) begin
                    // Rising edge: the command bit's edge carries no read data.
                    spi_clk_next = 1'b1;
                    if (bit_cnt != '0 && rw_lat == CMD_READ) begin
                        rx_shift_next = {rx_shift[DATA_WIDTH-2:0], miso};
                    end
                end else if (half_tick) begin
                    spi_clk_next = 1'b0;
                    if (bit_cnt == BIT_W'(DATA_WIDTH)) begin
                        bit_cnt_next = '0;
                        mosi_next    = 1'b0;
                        state_next   = HOLD;
                    end else begin
                        bit_cnt_next  = bit_cnt + 1'b1;
                        mosi_next     = (rw_lat == CMD_WRITE) ? tx_shift[DATA_WIDTH-1] : 1'b0;
                        tx_shift_next = tx_shift << 1;
                    end
                end
            end
            HOLD: begin
                if (half_tick) begin
                    state_next = GAP;
                    cs_n_next  = 1'b1;
                    mosi_next  = 1'b0;
                    done_next  = 1'b1;
                    if (rw_lat == CMD_READ) begin
                        rx_data_next = rx_shift;
                    end
                end
            end
            GAP: begin
                if (half_tick) begin
                    state_next = IDLE;
                    busy_next  = 1'b0;
                end
            end
            default: state_next = IDLE;
        endcase
    end

endmodule

// File: tb/tb_spi_master_ctrl.sv
// Directed bench for spi_master_ctrl: a scoreboard queue holds expected done cycle / rx_data
// per frame, and per-instance monitors pop it on every done pulse.
module tb_spi_master_ctrl;
    import spi_pkg::*;

    typedef struct {
        int          cyc;
        logic [15:0] rx;
    } exp_t;

    logic sclk = 1'b0;
    logic rst  = 1'b1;
    int   cyc  = 0;
    int   tests = 0;
    int   fails = 0;

    always #5 sclk = ~sclk;
    always @(posedge sclk) cyc <= cyc + 1;

    // Instance A: defaults (DATA_WIDTH=8, CLK_DIV=4)
    logic       start_a = 1'b0, rw_a = 1'b0;
    logic [7:0] tx_a = 8'h00, rx_a;
    logic       busy_a, done_a, cs_n_a, spi_clk_a, mosi_a, miso_a;

    // Instance B: DATA_WIDTH=16, CLK_DIV=1
    logic        start_b = 1'b0, rw_b = 1'b0;
    logic [15:0] tx_b = 16'h0000, rx_b;
    logic        busy_b, done_b, cs_n_b, spi_clk_b, mosi_b;

    spi_master_ctrl #(.DATA_WIDTH(8), .CLK_DIV(4)) dut_a (
        .sclk(sclk), .rst(rst), .start(start_a), .rw(rw_a), .tx_data(tx_a),
        .busy(busy_a), .done(done_a), .rx_data(rx_a),
        .cs_n(cs_n_a), .spi_clk(spi_clk_a), .mosi(mosi_a), .miso(miso_a)
    );

    spi_master_ctrl #(.DATA_WIDTH(16), .CLK_DIV(1)) dut_b (
        .sclk(sclk), .rst(rst), .start(start_b), .rw(rw_b), .tx_data(tx_b),
        .busy(busy_b), .done(done_b), .rx_data(rx_b),
        .cs_n(cs_n_b), .spi_clk(spi_clk_b), .mosi(mosi_b), .miso(1'b0)
    );

    // Mode-0 slave model: presents data MSB first, advancing after each spi_clk fall.
    logic [7:0] slave_data = 8'h00;
    int         falls_a = 0;

    always @(negedge spi_clk_a or posedge cs_n_a) begin
        if (cs_n_a) falls_a = 0;
        else        falls_a = falls_a + 1;
    end

    always_comb begin
        miso_a = 1'b0;
        if (falls_a >= 1 && falls_a <= 8) miso_a = slave_data[3'(8 - falls_a)];
    end

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    exp_t       q_a[$];
    exp_t       q_b[$];
    int         rises_a = 0, first_rise_a = 0, last_rise_a = 0, cs_fall_a = 0, cs_rise_a = 0;
    int         rises_b = 0, first_rise_b = 0, last_rise_b = 0, cs_fall_b = 0, cs_rise_b = 0;
    logic [8:0]  bits_a = '0;
    logic [16:0] bits_b = '0;
    logic prev_clk_a = 1'b0, prev_cs_a = 1'b1, prev_clk_b = 1'b0, prev_cs_b = 1'b1;

    always @(negedge sclk) begin
        exp_t e;
        if (!cs_n_a && prev_cs_a) begin
            cs_fall_a = cyc;
            rises_a   = 0;
            bits_a    = '0;
        end
        if (cs_n_a && !prev_cs_a) cs_rise_a = cyc;
        if (!cs_n_a && spi_clk_a && !prev_clk_a) begin
            if (rises_a == 0) first_rise_a = cyc;
            last_rise_a = cyc;
            rises_a++;
            bits_a = {bits_a[7:0], mosi_a};
        end
        prev_clk_a = spi_clk_a;
        prev_cs_a  = cs_n_a;
        if (done_a) begin
            check_output("a_done_expected", 32'(q_a.size() != 0), 1);
            if (q_a.size() != 0) begin
                e = q_a.pop_front();
                check_output("a_done_cycle", cyc, e.cyc);
                check_output("a_rx_data", 32'(rx_a), 32'(e.rx));
            end
        end
    end

    always @(negedge sclk) begin
        exp_t e;
        if (!cs_n_b && prev_cs_b) begin
            cs_fall_b = cyc;
            rises_b   = 0;
            bits_b    = '0;
        end
        if (cs_n_b && !prev_cs_b) cs_rise_b = cyc;
        if (!cs_n_b && spi_clk_b && !prev_clk_b) begin
            if (rises_b == 0) first_rise_b = cyc;
            last_rise_b = cyc;
            rises_b++;
            bits_b = {bits_b[15:0], mosi_b};
        end
        prev_clk_b = spi_clk_b;
        prev_cs_b  = cs_n_b;
        if (done_b) begin
            check_output("b_done_expected", 32'(q_b.size() != 0), 1);
            if (q_b.size() != 0) begin
                e = q_b.pop_front();
                check_output("b_done_cycle", cyc, e.cyc);
                check_output("b_rx_data", 32'(rx_b), 32'(e.rx));
            end
        end
    end

    // One frame on instance A; rw/tx are scrambled right after acceptance.
    task automatic apply_stimulus(input logic rw_v, input logic [7:0] tx_v, input logic [7:0] slave_v,
                                  input logic [7:0] exp_rx, input logic [8:0] exp_bits);
        int t0;
        int end_cyc;
        @(negedge sclk);
        slave_data = slave_v;
        start_a    = 1'b1;
        rw_a       = rw_v;
        tx_a       = tx_v;
        t0         = cyc;
        q_a.push_back('{t0 + 77, 16'(exp_rx)});
        @(negedge sclk);
        start_a = 1'b0;
        rw_a    = ~rw_v;
        tx_a    = ~tx_v;
        end_cyc = -1;
        for (int i = 0; i < 300; i++) begin
            @(negedge sclk);
            if (!busy_a) begin
                end_cyc = cyc;
                break;
            end
        end
        check_output("a_busy_drop", end_cyc - t0, 81);
        check_output("a_cs_fall", cs_fall_a - t0, 1);
        check_output("a_cs_rise", cs_rise_a - t0, 77);
        check_output("a_rises", rises_a, 9);
        check_output("a_rise_span", last_rise_a - first_rise_a, 64);
        check_output("a_mosi_bits", 32'(bits_a), 32'(exp_bits));
    endtask

    initial begin
        int t0;
        int end_cyc;
        int dones;

        // Reset with random inputs
        repeat (4) begin
            @(negedge sclk);
            start_a = 1'($urandom_range(1, 0));
            rw_a    = 1'($urandom_range(1, 0));
            tx_a    = 8'($urandom);
            start_b = 1'($urandom_range(1, 0));
            tx_b    = 16'($urandom);
        end
        check_output("rst_cs_n", 32'(cs_n_a), 1);
        check_output("rst_spi_clk", 32'(spi_clk_a), 0);
        check_output("rst_mosi", 32'(mosi_a), 0);
        check_output("rst_busy", 32'(busy_a), 0);
        check_output("rst_done", 32'(done_a), 0);
        check_output("rst_rx_data", 32'(rx_a), 0);
        check_output("rst_b_cs_n", 32'(cs_n_b), 1);
        start_a = 1'b0;
        start_b = 1'b0;
        @(negedge sclk);
        rst = 1'b0;
        repeat (2) @(negedge sclk);

        apply_stimulus(CMD_WRITE, 8'hA5, 8'h00, 8'h00, 9'h1A5);
        apply_stimulus(CMD_READ,  8'h00, 8'h3C, 8'h3C, 9'h000);
        apply_stimulus(CMD_READ,  8'hFF, 8'h0C, 8'h0C, 9'h000);
        apply_stimulus(CMD_WRITE, 8'h5A, 8'hFF, 8'h0C, 9'h15A);

        // start held high through a whole frame: one done, re-accepted in first IDLE cycle
        @(negedge sclk);
        start_a = 1'b1;
        rw_a    = CMD_WRITE;
        tx_a    = 8'h81;
        t0      = cyc;
        q_a.push_back('{t0 + 77, 16'h000C});
        q_a.push_back('{t0 + 81 + 77, 16'h000C});
        dones = 0;
        repeat (82) begin
            @(negedge sclk);
            if (done_a) dones++;
        end
        start_a = 1'b0;
        check_output("held_start_dones", dones, 1);
        end_cyc = -1;
        for (int i = 0; i < 300; i++) begin
            @(negedge sclk);
            if (!busy_a) begin
                end_cyc = cyc;
                break;
            end
        end
        check_output("held_start_second_cs_fall", cs_fall_a - t0, 82);
        check_output("held_start_busy_drop", end_cyc - t0, 162);
        check_output("held_start_bits", 32'(bits_a), 32'h181);

        // Reset at cycle 30 of a READ: immediate abort, no done
        @(negedge sclk);
        slave_data = 8'hFF;
        start_a    = 1'b1;
        rw_a       = CMD_READ;
        tx_a       = 8'h00;
        t0         = cyc;
        @(negedge sclk);
        start_a = 1'b0;
        while (cyc - t0 < 30) @(negedge sclk);
        rst = 1'b1;
        #1;
        check_output("abort_cs_n", 32'(cs_n_a), 1);
        check_output("abort_spi_clk", 32'(spi_clk_a), 0);
        check_output("abort_busy", 32'(busy_a), 0);
        check_output("abort_rx_data", 32'(rx_a), 0);
        repeat (3) @(negedge sclk);
        rst = 1'b0;
        repeat (2) @(negedge sclk);
        apply_stimulus(CMD_WRITE, 8'h3C, 8'h00, 8'h00, 9'h13C);

        // Instance B: CLK_DIV=1, 16-bit WRITE 0x8001
        @(negedge sclk);
        start_b = 1'b1;
        rw_b    = CMD_WRITE;
        tx_b    = 16'h8001;
        t0      = cyc;
        q_b.push_back('{t0 + 36, 16'h0000});
        @(negedge sclk);
        start_b = 1'b0;
        tx_b    = 16'h0000;
        end_cyc = -1;
        for (int i = 0; i < 200; i++) begin
            @(negedge sclk);
            if (!busy_b) begin
                end_cyc = cyc;
                break;
            end
        end
        check_output("b_busy_drop", end_cyc - t0, 37);
        check_output("b_cs_fall", cs_fall_b - t0, 1);
        check_output("b_cs_rise", cs_rise_b - t0, 36);
        check_output("b_rises", rises_b, 17);
        check_output("b_rise_span", last_rise_b - first_rise_b, 32);
        check_output("b_mosi_bits", 32'(bits_b), 32'h18001);

        repeat (4) @(negedge sclk);
        check_output("a_queue_drained", q_a.size(), 0);
        check_output("b_queue_drained", q_b.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
